// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a show-ahead FIFO and sends 8N1/8N2 frames.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_q,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_en,
  input  logic             parity_odd,
`endif
  output logic             fifo_rdreq,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  // state  | meaning
  // IDLE   | line high, waiting for tx_en and a byte
  // START  | start bit (txd=0)
  // DATA   | 8 data bits, LSB first
  // PARITY | parity bit (parity build only)
  // STOP   | one or two stop bits (txd=1)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lat;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             stop2_lat;
  logic             bit_end;
  logic             last_stop;
  logic             pop;
`ifdef UART_TX_PARITY_EN
  logic             par_en_lat;
  logic             par_bit;
`endif

  assign bit_end   = (div_cnt == div_lat - DIV_W'(1));
  assign last_stop = (bit_idx[0] == stop2_lat);
  // Reset gates the pop so the FIFO is never drained while held in reset.
  assign pop = sclr & tx_en & ~fifo_empty &
               ((state == IDLE) | ((state == STOP) & bit_end & last_stop));

  assign fifo_rdreq = pop;
  assign busy       = (state != IDLE);
  assign tx_done    = (state == STOP) & bit_end & last_stop;

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    txd      = 1'b1;
    case (state)
      IDLE: begin
        if (pop) state_nx = START;
      end
      START: begin
        txd = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        txd = shift[0];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nx = par_en_lat ? PARITY : STOP;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd = par_bit;
        if (bit_end) state_nx = STOP;
      end
`endif
      STOP: begin
        if (bit_end && last_stop) state_nx = pop ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      div_cnt    <= '0;
      div_lat    <= '0;
      shift      <= '0;
      bit_idx    <= '0;
      stop2_lat  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_lat <= 1'b0;
      par_bit    <= 1'b0;
`endif
    end else if (pop) begin
      shift      <= fifo_q;
      div_lat    <= (baud_div == '0) ? DIV_W'(1) : baud_div;
      stop2_lat  <= stop2;
      div_cnt    <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      // Parity is taken from the byte at pop time since the shifter consumes it.
      par_en_lat <= parity_en;
      par_bit    <= (^fifo_q) ^ parity_odd;
`endif
    end else if (state != IDLE) begin
      div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
      if (bit_end) begin
        case (state)
          DATA: begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          STOP:    bit_idx <= last_stop ? 3'd0 : bit_idx + 3'd1;
          default: bit_idx <= bit_idx;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frame-level reference model plus directed pins.
module tb_uart_tx_serializer;

  localparam int DIV_W = 16;

  logic             clock;
  logic             sclr;
  logic             tx_en;
  logic [DIV_W-1:0] baud_div;
  logic             stop2;
  logic             fifo_empty;
  logic [7:0]       fifo_q;
  logic             fifo_rdreq;
  logic             txd;
  logic             busy;
  logic             tx_done;
`ifdef UART_TX_PARITY_EN
  logic             parity_en;
  logic             parity_odd;
`endif

  uart_tx_serializer #(.DIV_W(DIV_W)) dut (
    .clock      (clock),
    .sclr       (sclr),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .stop2      (stop2),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
`ifdef UART_TX_PARITY_EN
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
`endif
    .fifo_rdreq (fifo_rdreq),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  bit txd_log[$];
  bit rd_log[$];
  bit done_log[$];
  bit busy_log[$];

  // Reference model: a frame is a list of line bits, each held m_div cycles.
  bit m_active = 0;
  int m_elapsed = 0;
  int m_div = 1;
  int m_nbits = 10;
  bit m_bits[12];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_q     = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  task automatic clear_logs();
    txd_log.delete(); rd_log.delete(); done_log.delete(); busy_log.delete();
  endtask

  function automatic int find_rd(input int from);
    for (int i = from; i < rd_log.size(); i++) if (rd_log[i]) return i;
    return -1;
  endfunction

  function automatic int find_done(input int from);
    for (int i = from; i < done_log.size(); i++) if (done_log[i]) return i;
    return -1;
  endfunction

  function automatic int count_rd();
    int n = 0;
    foreach (rd_log[i]) if (rd_log[i]) n++;
    return n;
  endfunction

  task automatic step();
    bit e_txd, e_busy, e_done, e_pop, dut_rd;
    int n;
    @(negedge clock);
    if (m_active) begin
      e_done = (m_elapsed == m_nbits * m_div - 1);
      e_txd  = m_bits[m_elapsed / m_div];
      e_busy = 1'b1;
    end else begin
      e_done = 1'b0; e_txd = 1'b1; e_busy = 1'b0;
    end
    e_pop = sclr && tx_en && !fifo_empty && (!m_active || e_done);
    chk("cyc_rdreq", int'(fifo_rdreq), int'(e_pop));
    chk("cyc_txd", int'(txd), int'(e_txd));
    chk("cyc_busy", int'(busy), int'(e_busy));
    chk("cyc_tx_done", int'(tx_done), int'(e_done));
    txd_log.push_back(txd); rd_log.push_back(fifo_rdreq);
    done_log.push_back(tx_done); busy_log.push_back(busy);
    dut_rd = fifo_rdreq;
    @(posedge clock);
    #1;
    if (!sclr) m_active = 0;
    else if (e_pop) begin
      m_active  = 1;
      m_elapsed = 0;
      m_div     = (baud_div == 0) ? 1 : int'(baud_div);
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[i + 1] = fifo_q[i];
      n = 9;
`ifdef UART_TX_PARITY_EN
      if (parity_en) begin m_bits[n] = (^fifo_q) ^ parity_odd; n++; end
`endif
      m_bits[n] = 1'b1; n++;
      if (stop2) begin m_bits[n] = 1'b1; n++; end
      m_nbits = n;
    end else if (m_active) begin
      if (e_done) m_active = 0;
      else m_elapsed++;
    end
    if (dut_rd && fq.size() > 0) void'(fq.pop_front());
    refresh();
  endtask

  int r, r2, d, d2;
  logic [10:0] v;
  int seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    sclr = 1'b0; tx_en = 1'b0; baud_div = 16'd4; stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_en = 1'b0; parity_odd = 1'b0;
`endif
    refresh();
    repeat (3) step();
    push(8'h55); tx_en = 1'b1; #1;
    chk("reset_txd", int'(txd), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_tx_done", int'(tx_done), 0);
    chk("reset_rdreq", int'(fifo_rdreq), 0);
    fq.delete(); refresh();
    step();
    sclr = 1'b1;
    repeat (2) step();

    // Single byte 0xA5 at 4 cycles/bit
    clear_logs();
    push(8'hA5);
    repeat (46) step();
    r = find_rd(0);
    chk("single_rd_found", int'(r >= 0), 1);
    if (r < 0) r = 0;
    chk("single_rd_count", count_rd(), 1);
    chk("single_done_at", find_done(0) - r, 40);
    for (int b = 0; b < 10; b++) chk("single_txd_bit", int'(txd_log[r + 2 + 4 * b]), seq_a5[b]);
    chk("single_busy_after", int'(busy_log[r + 41]), 0);

    // Back-to-back 0x00, 0xFF at 2 cycles/bit
    baud_div = 16'd2;
    clear_logs();
    push(8'h00); push(8'hFF);
    repeat (46) step();
    r = find_rd(0); if (r < 0) r = 0;
    r2 = find_rd(r + 1);
    chk("b2b_gap", r2 - r, 20);
    if (r2 < 0) r2 = 0;
    chk("b2b_done_with_rd", int'(done_log[r2]), 1);
    chk("b2b_next_start", int'(txd_log[r2 + 1]), 0);
    d2 = find_done(r2 + 1);
    chk("b2b_total", d2 - r, 40);

    // Divisor 0 (treated as 1), two stop bits, 0x81
    baud_div = 16'd0; stop2 = 1'b1;
    clear_logs();
    push(8'h81);
    repeat (14) step();
    r = find_rd(0); if (r < 0) r = 0;
    v = '0;
    for (int i = 1; i <= 11; i++) v = {v[9:0], txd_log[r + i]};
    chk("div0_frame_bits", int'(v), int'(11'b01000000111));
    chk("div0_done_at", find_done(0) - r, 11);

    // tx_en dropped and divisor changed mid-frame
    baud_div = 16'd4; stop2 = 1'b0;
    clear_logs();
    push(8'h3C); push(8'hC3);
    repeat (10) step();
    tx_en = 1'b0; baud_div = 16'd8;
    repeat (40) step();
    r = find_rd(0); if (r < 0) r = 0;
    chk("midchg_rd_count", count_rd(), 1);
    chk("midchg_done_at", find_done(0) - r, 40);
    clear_logs();
    tx_en = 1'b1;
    repeat (85) step();
    r = find_rd(0);
    chk("midchg_second_rd", int'(r >= 0), 1);
    if (r < 0) r = 0;
    chk("midchg_second_done", find_done(r + 1) - r, 80);
    chk("midchg_second_bit0", int'(txd_log[r + 1 + 8 + 4]), 1);

    // Async reset mid-frame while txd=0
    baud_div = 16'd4;
    push(8'h12); push(8'h34);
    repeat (2) step();
    chk("rst_pre_txd", int'(txd), 0);
    #2 sclr = 1'b0;
    m_active = 0;
    #1;
    chk("rst_async_txd", int'(txd), 1);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_rdreq", int'(fifo_rdreq), 0);
    repeat (2) step();
    sclr = 1'b1;
    clear_logs();
    repeat (45) step();
    chk("rst_after_rd_count", count_rd(), 1);

`ifdef UART_TX_PARITY_EN
    baud_div = 16'd2; parity_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      parity_odd = k[0];
      clear_logs();
      push(8'h07);
      repeat (26) step();
      r = find_rd(0); if (r < 0) r = 0;
      chk("parity_done_at", find_done(0) - r, 22);
      chk("parity_bit", int'(txd_log[r + 1 + 2 * 9]), k == 0 ? 1 : 0);
    end
    parity_en = 1'b0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0 && fq.size() < 16) push(8'($urandom));
      if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
      baud_div = 16'($urandom_range(0, 3));
      stop2 = 1'($urandom);
`ifdef UART_TX_PARITY_EN
      parity_en = 1'($urandom); parity_odd = 1'($urandom);
`endif
      step();
    end
    tx_en = 1'b1;
    repeat (300) step();
    chk("drain_fifo_empty", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
